// File: rtl/sr_flag_arbiter.sv
// Round-robin owner of a shared external SR ownership flag: drives set/rst,
// confirms each transition on Q, and grants one requester at a time.
module sr_flag_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   rel,
    input  logic           sr_q,
    output logic           sr_set,
    output logic           sr_rst,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic           timeout
);

    localparam int CW = (HOLD_MAX < 2) ? 2 : $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACQ, OWN, REL} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt, owner_nxt, winner;
    logic [CW-1:0]  hold_cnt, hold_nxt;
    logic           found, hold_hit, timeout_nxt;

    // First set request at or after the pointer, wrapping at N-1.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    assign hold_hit = (HOLD_MAX != 0) && (hold_cnt == CW'(HOLD_MAX));

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                // A flag already set with no owner must be cleared before arbitrating.
                if (sr_q) begin
                    state_nxt = REL;
                end else if (found) begin
                    owner_nxt = winner;
                    state_nxt = ACQ;
                end
            end
            ACQ: begin
                if (sr_q) begin
                    state_nxt = OWN;
                    hold_nxt  = CW'(1);
                    ptr_nxt   = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
                end
            end
            OWN: begin
                if (hold_cnt != '1)
                    hold_nxt = hold_cnt + 1'b1;
                if (rel[owner]) begin
                    state_nxt = REL;
                end else if (hold_hit) begin
                    state_nxt   = REL;
                    timeout_nxt = 1'b1;
                end
            end
            REL: begin
                if (!sr_q)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign sr_set = (state == ACQ);
    assign sr_rst = (state == REL);
    assign busy   = (state != IDLE);
    assign gnt    = (state == OWN) ? (N'(1) << owner) : '0;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter with behavioural SR flip-flop models.
module tb_sr_flag_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0, rel = '0, req_b = '0, rel_b = '0;
    logic       qa = 1'b0, qb = 1'b0, q_preset = 1'b0;

    logic       sr_set_a, sr_rst_a, busy_a, timeout_a;
    logic [3:0] gnt_a;
    logic [1:0] owner_a;
    logic       sr_set_b, sr_rst_b, busy_b, timeout_b;
    logic [3:0] gnt_b;
    logic [1:0] owner_b;

    int errors = 0, checks = 0, both_hi = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.N(4), .IDW(2), .HOLD_MAX(16)) dut_a (
        .clk(clk), .rst(rst_n), .req(req), .rel(rel), .sr_q(qa),
        .sr_set(sr_set_a), .sr_rst(sr_rst_a), .gnt(gnt_a), .owner(owner_a),
        .busy(busy_a), .timeout(timeout_a)
    );

    sr_flag_arbiter #(.N(4), .IDW(2), .HOLD_MAX(4)) dut_b (
        .clk(clk), .rst(rst_n), .req(req_b), .rel(rel_b), .sr_q(qb),
        .sr_set(sr_set_b), .sr_rst(sr_rst_b), .gnt(gnt_b), .owner(owner_b),
        .busy(busy_b), .timeout(timeout_b)
    );

    // SR flip-flops: Q follows set/rst one clock later, unaffected by the controller reset.
    always @(posedge clk) begin
        if (q_preset)      qa <= 1'b1;
        else if (sr_set_a) qa <= 1'b1;
        else if (sr_rst_a) qa <= 1'b0;
    end

    always @(posedge clk) begin
        if (sr_set_b)      qb <= 1'b1;
        else if (sr_rst_b) qb <= 1'b0;
    end

    always @(negedge clk) begin
        if ((sr_set_a && sr_rst_a) || (sr_set_b && sr_rst_b))
            both_hi++;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] rel;
        logic [3:0] gnt;
        logic       set;
        logic       rst;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; rel = '0; req_b = '0; rel_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 20; i++) begin
            if (!busy_a) break;
            tick();
        end
        chk("idle reached", 32'(busy_a), 32'(0));
    endtask

    task automatic wait_gnt_a(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (gnt_a != 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 32'(1));
    endtask

    int         exp_order [5];
    int         ng, last_hi, multi, n2, to_cnt;
    logic [3:0] prev, e;
    bit         got3, saw_set;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          req      rel      gnt      set rst busy to
        tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 1,  0,  1,   0};
        tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 1,  0,  1,   0};
        tbl[2]  = '{4'b0001, 4'b0000, 4'b0001, 0,  0,  1,   0};
        tbl[3]  = '{4'b0001, 4'b0000, 4'b0001, 0,  0,  1,   0};
        tbl[4]  = '{4'b0001, 4'b0000, 4'b0001, 0,  0,  1,   0};
        tbl[5]  = '{4'b0001, 4'b0000, 4'b0001, 0,  0,  1,   0};
        tbl[6]  = '{4'b0001, 4'b0000, 4'b0001, 0,  0,  1,   0};
        tbl[7]  = '{4'b0000, 4'b0001, 4'b0000, 0,  1,  1,   0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 0,  1,  1,   0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 0,  0,  0,   0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 0,  0,  0,   0};
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset gnt", 32'(gnt_a), 32'(0));
        chk("reset sr_set", 32'(sr_set_a), 32'(0));
        chk("reset sr_rst", 32'(sr_rst_a), 32'(0));
        chk("reset busy", 32'(busy_a), 32'(0));
        chk("reset owner", 32'(owner_a), 32'(0));
        chk("reset timeout", 32'(timeout_a), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, table-driven
        for (int s = 0; s < 11; s++) begin
            req = tbl[s].req;
            rel = tbl[s].rel;
            tick();
            chk($sformatf("single[%0d] gnt", s), 32'(gnt_a), 32'(tbl[s].gnt));
            chk($sformatf("single[%0d] sr_set", s), 32'(sr_set_a), 32'(tbl[s].set));
            chk($sformatf("single[%0d] sr_rst", s), 32'(sr_rst_a), 32'(tbl[s].rst));
            chk($sformatf("single[%0d] busy", s), 32'(busy_a), 32'(tbl[s].busy));
            chk($sformatf("single[%0d] timeout", s), 32'(timeout_a), 32'(tbl[s].to));
        end

        // Contention: all request, each owner releases after one OWN cycle
        do_reset();
        ng = 0; last_hi = -100; multi = 0; prev = '0;
        req = 4'hF;
        for (int c = 0; c < 200 && ng < 5; c++) begin
            tick();
            if ((gnt_a & (gnt_a - 4'd1)) != 0) multi++;
            if (prev == 0 && gnt_a != 0) begin
                e = 4'b0001 << exp_order[ng];
                chk($sformatf("rr grant %0d", ng), 32'(gnt_a), 32'(e));
                if (ng > 0)
                    chk($sformatf("rr gap %0d >=3", ng), 32'((c - last_hi - 1) >= 3), 32'(1));
                ng++;
            end
            if (gnt_a != 0) last_hi = c;
            prev = gnt_a;
            rel  = gnt_a;
        end
        chk("rr grant count", 32'(ng), 32'(5));
        chk("rr multi-hot cycles", 32'(multi), 32'(0));
        req = '0;
        tick();
        rel = '0;
        wait_idle_a();

        // Foreign release is ignored
        do_reset();
        req = 4'b0001;
        wait_gnt_a("foreign grant seen");
        rel = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("foreign[%0d] gnt", i), 32'(gnt_a), 32'(4'b0001));
            chk($sformatf("foreign[%0d] sr_rst", i), 32'(sr_rst_a), 32'(0));
        end
        rel = 4'b0001;
        req = '0;
        tick();
        chk("owner release sr_rst", 32'(sr_rst_a), 32'(1));
        chk("owner release gnt", 32'(gnt_a), 32'(0));
        rel = '0;
        wait_idle_a();

        // Hold limit on the HOLD_MAX=4 instance
        do_reset();
        req_b = 4'b1100;
        n2 = 0; to_cnt = 0; got3 = 1'b0; prev = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gnt_b == 4'b0100) n2++;
            if (timeout_b) begin
                to_cnt++;
                chk("timeout in first REL sr_rst", 32'(sr_rst_b), 32'(1));
                chk("timeout prev gnt", 32'(prev), 32'(4'b0100));
            end
            if (gnt_b == 4'b1000) begin
                got3 = 1'b1;
                break;
            end
            prev = gnt_b;
        end
        chk("hold gnt cycles", 32'(n2), 32'(4));
        chk("hold timeout pulses", 32'(to_cnt), 32'(1));
        chk("hold next grant to 3", 32'(got3), 32'(1));
        chk("hold main timeout", 32'(timeout_a), 32'(0));

        // Stale flag out of reset
        do_reset();
        rst_n = 1'b0;
        q_preset = 1'b1;
        tick();
        q_preset = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("stale c1 sr_rst", 32'(sr_rst_a), 32'(1));
        chk("stale c1 busy", 32'(busy_a), 32'(1));
        chk("stale c1 gnt", 32'(gnt_a), 32'(0));
        chk("stale c1 timeout", 32'(timeout_a), 32'(0));
        tick();
        chk("stale c2 sr_rst", 32'(sr_rst_a), 32'(1));
        chk("stale c2 gnt", 32'(gnt_a), 32'(0));
        tick();
        chk("stale c3 busy", 32'(busy_a), 32'(0));
        chk("stale c3 sr_rst", 32'(sr_rst_a), 32'(0));
        chk("stale c3 gnt", 32'(gnt_a), 32'(0));

        // Asynchronous reset while requester 1 owns the flag
        do_reset();
        req = 4'b0010;
        wait_gnt_a("midown grant seen");
        chk("midown gnt", 32'(gnt_a), 32'(4'b0010));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst gnt", 32'(gnt_a), 32'(0));
        chk("async rst sr_set", 32'(sr_set_a), 32'(0));
        chk("async rst sr_rst", 32'(sr_rst_a), 32'(0));
        chk("async rst busy", 32'(busy_a), 32'(0));
        chk("async rst owner", 32'(owner_a), 32'(0));
        req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post rst cleanup sr_rst", 32'(sr_rst_a), 32'(1));
        chk("post rst cleanup sr_set", 32'(sr_set_a), 32'(0));
        saw_set = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sr_set_a) saw_set = 1'b1;
            if (gnt_a != 0) break;
        end
        chk("post rst acquire seen", 32'(saw_set), 32'(1));
        chk("post rst grant ptr 0", 32'(gnt_a), 32'(4'b0010));
        req = '0;
        rel = 4'b0010;
        tick();
        rel = '0;
        wait_idle_a();

        chk("set/rst never both high", 32'(both_hi), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
